// File: rtl/ysyx_220066_mem_pkg.sv
// rtl/ysyx_220066_mem_pkg.sv - MemOp encodings, responder states and lane-size helper
package ysyx_220066_mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // op[1:0] is the log2 access size for every legal load and store
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_220066_lsu_align.sv
// rtl/ysyx_220066_lsu_align.sv - byte-lane placement, load extraction and legality flags
module ysyx_220066_lsu_align
  import ysyx_220066_mem_pkg::*;
(
  input  logic        i_wr,
  input  logic [2:0]  i_op,
  input  logic [2:0]  i_lsb,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_wmask,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [5:0]  w_shift;
  logic [63:0] w_raw;

  always_comb begin
    w_shift      = {i_lsb, 3'b000};
    o_wmask      = size_mask(i_op[1:0]) << i_lsb;
    o_wdata      = i_wdata << w_shift;
    w_raw        = i_rdata >> w_shift;
    o_rdata      = w_raw;
    o_misaligned = 1'b0;
    o_illegal    = i_wr ? i_op[2] : (i_op == 3'b111);

    // op[2] selects zero extension; ld has no unsigned form so it passes through
    case (i_op[1:0])
      2'b00: o_rdata = i_op[2] ? {56'd0, w_raw[7:0]}  : {{56{w_raw[7]}},  w_raw[7:0]};
      2'b01: o_rdata = i_op[2] ? {48'd0, w_raw[15:0]} : {{48{w_raw[15]}}, w_raw[15:0]};
      2'b10: o_rdata = i_op[2] ? {32'd0, w_raw[31:0]} : {{32{w_raw[31]}}, w_raw[31:0]};
      default: o_rdata = w_raw;
    endcase

    case (i_op[1:0])
      2'b01:   o_misaligned = i_lsb[0];
      2'b10:   o_misaligned = |i_lsb[1:0];
      2'b11:   o_misaligned = |i_lsb;
      default: o_misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_220066_dmem_resp.sv
// rtl/ysyx_220066_dmem_resp.sv - single-outstanding data-port responder with backend timeout
module ysyx_220066_dmem_resp
  import ysyx_220066_mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wmask,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ack
);

  state_e            r_state;
  state_e            w_next;
  logic              r_wr;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [15:0]       r_cnt;
  logic [63:0]       r_rdata;
  logic              r_err;

  logic              w_idle;
  logic              w_accept;
  logic              w_bad;
  logic              w_timeout;
  logic              w_wr;
  logic [2:0]        w_op;
  logic [2:0]        w_lsb;
  logic [7:0]        w_wmask;
  logic [63:0]       w_wdata;
  logic [63:0]       w_ext;
  logic              w_misaligned;
  logic              w_illegal;

  // In IDLE the aligner judges the incoming request; afterwards it serves the latched one
  assign w_idle    = (r_state == IDLE);
  assign w_wr      = w_idle ? req_wr : r_wr;
  assign w_op      = w_idle ? req_op : r_op;
  assign w_lsb     = w_idle ? req_addr[2:0] : r_addr[2:0];
  assign req_ready = w_idle & rst;
  assign w_accept  = req_valid & req_ready;
  assign w_bad     = w_misaligned | w_illegal;
  assign w_timeout = (r_cnt == 16'(TIMEOUT - 1));

  ysyx_220066_lsu_align u_align (
    .i_wr         (w_wr),
    .i_op         (w_op),
    .i_lsb        (w_lsb),
    .i_wdata      (r_wdata),
    .i_rdata      (mem_rdata),
    .o_wmask      (w_wmask),
    .o_wdata      (w_wdata),
    .o_rdata      (w_ext),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_bad ? RESP : ACCESS;
      ACCESS:  if (mem_ack || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wr    <= 1'b0;
      r_op    <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 64'd0;
      r_cnt   <= 16'd0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_wr    <= req_wr;
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= 16'd0;
        if (w_bad) begin
          r_rdata <= 64'd0;
          r_err   <= 1'b1;
        end
      end
      if (r_state == ACCESS) begin
        r_cnt <= r_cnt + 16'd1;
        // ack takes priority over a timeout landing on the same edge
        if (mem_ack) begin
          r_rdata <= r_wr ? 64'd0 : w_ext;
          r_err   <= 1'b0;
        end else if (w_timeout) begin
          r_rdata <= 64'd0;
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_en     = (r_state == ACCESS);
  assign mem_we     = mem_en & r_wr;
  assign mem_addr   = {r_addr[ADDR_W-1:3], 3'b000};
  assign mem_wmask  = mem_we ? w_wmask : 8'd0;
  assign mem_wdata  = mem_we ? w_wdata : 64'd0;

endmodule
